// File: rtl/aes_block_stream.sv
`timescale 1ns/1ps
// Stream controller around an iterative AES-128 core: packs 32-bit words into blocks, optional CBC, unpacks ciphertext.
// Latency: block handed to core on the edge accepting its last word; first ciphertext word valid the edge after core_done.
// Backpressure: in_ready only in LOAD; out_data/out_last hold while out_ready is low; no overlap between blocks.
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   start, key, iv, cbc_en     message setup, sampled only in IDLE
//   in_valid/in_ready/in_data/in_last      plaintext word stream (MSB word first)
//   out_valid/out_ready/out_data/out_last  ciphertext word stream (MSB word first)
//   busy, error                status: not idle / sticky core timeout
//   core_din, core_key, core_reset, core_ctxt, core_done   AES core handshake
module aes_block_stream #(
   parameter int WAIT_MAX = 31,
   parameter int GUARD    = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] iv,
   input  logic         cbc_en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_data,
   output logic         out_last,
   output logic         busy,
   output logic         error,
   output logic [127:0] core_din,
   output logic [127:0] core_key,
   output logic         core_reset,
   input  logic [127:0] core_ctxt,
   input  logic         core_done
);

   localparam int WW = $clog2(WAIT_MAX + 1);
   localparam logic [WW-1:0] GUARD_W = WW'(GUARD);
   localparam logic [WW-1:0] LAST_W  = WW'(WAIT_MAX - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN} state_t;

   state_t        state_q, state_d;
   logic [127:0]  key_q, key_d;
   logic [127:0]  chain_q, chain_d;
   logic [127:0]  blk_q, blk_d;
   logic [127:0]  din_q, din_d;
   logic [127:0]  ctxt_q, ctxt_d;
   logic          cbc_q, cbc_d;
   logic          final_q, final_d;
   logic          error_q, error_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [WW-1:0] wcnt_q, wcnt_d;

   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic [31:0]   out_data_q, out_data_d;
   logic          busy_q, busy_d;
   logic          core_reset_q, core_reset_d;

   logic [127:0]  blk_next;
   logic          in_acc;
   logic          out_acc;

   assign in_acc  = in_valid & in_ready_q;
   assign out_acc = out_valid_q & out_ready;

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      chain_d  = chain_q;
      blk_d    = blk_q;
      din_d    = din_q;
      ctxt_d   = ctxt_q;
      cbc_d    = cbc_q;
      final_d  = final_q;
      error_d  = error_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wcnt_d   = wcnt_q;
      blk_next = blk_q;

      // Word k lands at its final position; untouched slots stay zero,
      // which is the padding for a short final block.
      case (cnt_q)
         2'd0:    blk_next[127:96] = in_data;
         2'd1:    blk_next[95:64]  = in_data;
         2'd2:    blk_next[63:32]  = in_data;
         default: blk_next[31:0]   = in_data;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d   = key;
               cbc_d   = cbc_en;
               chain_d = cbc_en ? iv : 128'd0;
               error_d = 1'b0;
               cnt_d   = 2'd0;
               blk_d   = 128'd0;
               final_d = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (in_acc) begin
               blk_d = blk_next;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3 || in_last) begin
                  din_d   = blk_next ^ chain_q;
                  final_d = in_last;
                  wcnt_d  = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // core_done is left over from the previous block for a few
            // cycles after the core leaves reset, so it is masked early on.
            if (core_done && wcnt_q >= GUARD_W) begin
               ctxt_d  = core_ctxt;
               if (cbc_q) chain_d = core_ctxt;
               idx_d   = 2'd0;
               state_d = S_DRAIN;
            end else if (wcnt_q == LAST_W) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (out_acc) begin
               if (idx_q == 2'd3) begin
                  if (final_q) begin
                     state_d = S_IDLE;
                  end else begin
                     cnt_d   = 2'd0;
                     blk_d   = 128'd0;
                     state_d = S_LOAD;
                  end
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered from the next-state values so they change
      // together with the state and are glitch free.
      in_ready_d   = (state_d == S_LOAD);
      out_valid_d  = (state_d == S_DRAIN);
      busy_d       = (state_d != S_IDLE);
      core_reset_d = (state_d != S_WAIT);
      out_last_d   = (state_d == S_DRAIN) && (idx_d == 2'd3) && final_d;
      out_data_d   = 32'd0;
      if (state_d == S_DRAIN) begin
         case (idx_d)
            2'd0:    out_data_d = ctxt_d[127:96];
            2'd1:    out_data_d = ctxt_d[95:64];
            2'd2:    out_data_d = ctxt_d[63:32];
            default: out_data_d = ctxt_d[31:0];
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         key_q        <= 128'd0;
         chain_q      <= 128'd0;
         blk_q        <= 128'd0;
         din_q        <= 128'd0;
         ctxt_q       <= 128'd0;
         cbc_q        <= 1'b0;
         final_q      <= 1'b0;
         error_q      <= 1'b0;
         cnt_q        <= 2'd0;
         idx_q        <= 2'd0;
         wcnt_q       <= '0;
         in_ready_q   <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= 32'd0;
         busy_q       <= 1'b0;
         core_reset_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         chain_q      <= chain_d;
         blk_q        <= blk_d;
         din_q        <= din_d;
         ctxt_q       <= ctxt_d;
         cbc_q        <= cbc_d;
         final_q      <= final_d;
         error_q      <= error_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         wcnt_q       <= wcnt_d;
         in_ready_q   <= in_ready_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
         busy_q       <= busy_d;
         core_reset_q <= core_reset_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_data   = out_data_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign core_din   = din_q;
   assign core_key   = key_q;
   assign core_reset = core_reset_q;

endmodule

// File: tb/tb_aes_block_stream.sv
`timescale 1ns/1ps
// Directed bench for aes_block_stream with a lookup-based AES core stand-in.
// Latency: checks are taken at the falling edge after each rising edge.
// Backpressure: exercises out_ready stalls and in_valid during DRAIN.
module tb_aes_block_stream;

   localparam int WAIT_MAX = 31;
   localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P2 = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] iv = '0;
   logic         cbc_en = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [31:0]  out_data;
   logic         out_last;
   logic         busy;
   logic         error;
   logic [127:0] core_din;
   logic [127:0] core_key;
   logic         core_reset;
   logic [127:0] core_ctxt;
   logic         core_done;

   logic         force_done = 1'b0;
   logic         never_done = 1'b0;
   int           lat_cnt = 0;
   int           n_pass = 0;
   int           n_checks = 0;

   always #5 clk = ~clk;

   aes_block_stream #(.WAIT_MAX(WAIT_MAX), .GUARD(2)) dut (
      .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv), .cbc_en(cbc_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .error(error), .core_din(core_din), .core_key(core_key),
      .core_reset(core_reset), .core_ctxt(core_ctxt), .core_done(core_done)
   );

   // Core stand-in: knows the FIPS-197 vector, otherwise returns ~din.
   assign core_ctxt = (core_din == P && core_key == K) ? C : ~core_din;
   assign core_done = force_done || (!never_done && !core_reset && lat_cnt >= 12);
   always @(posedge clk) lat_cnt <= core_reset ? 0 : lat_cnt + 1;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic start_msg(input logic cbc, input logic [127:0] ivv);
      start  = 1'b1;
      key    = K;
      iv     = ivv;
      cbc_en = cbc;
      tick();
      start  = 1'b0;
      chk("start busy", busy, 1'b1);
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      for (int i = 0; i < 64 && in_ready !== 1'b1; i++) tick();
      chk("in_ready wait", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] b, input logic last);
      for (int w = 0; w < 4; w++) send_word(b[(3-w)*32 +: 32], last && (w == 3));
   endtask

   task automatic recv_word(input string tag, input logic [31:0] d, input logic last);
      for (int i = 0; i < 64 && out_valid !== 1'b1; i++) tick();
      chk({tag, " valid"}, out_valid, 1'b1);
      chk({tag, " data"}, out_data, d);
      chk({tag, " last"}, out_last, last);
      tick();
   endtask

   task automatic recv_block(input string tag, input logic [127:0] b, input logic last);
      for (int w = 0; w < 4; w++)
         recv_word($sformatf("%s w%0d", tag, w), b[(3-w)*32 +: 32], last && (w == 3));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst busy", busy, 1'b0);
      chk("rst core_reset", core_reset, 1'b1);
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst in_ready", in_ready, 1'b0);
      chk("rst error", error, 1'b0);
      chk("rst core_din", core_din, 128'd0);
      chk("rst core_key", core_key, 128'd0);
      reset = 1'b0;
      tick();

      // ECB FIPS-197 vector
      start_msg(1'b0, 128'd0);
      chk("ecb in_ready", in_ready, 1'b1);
      send_block(P, 1'b1);
      chk("ecb core_din", core_din, P);
      chk("ecb core_key", core_key, K);
      chk("ecb core_reset", core_reset, 1'b0);
      recv_block("ecb", C, 1'b1);
      chk("ecb idle", busy, 1'b0);

      // CBC two blocks, iv = 0
      start_msg(1'b1, 128'd0);
      send_block(P, 1'b0);
      chk("cbc b1 din", core_din, P);
      recv_block("cbc b1", C, 1'b0);
      chk("cbc between busy", busy, 1'b1);
      send_block(P2, 1'b1);
      chk("cbc b2 din", core_din, P);
      recv_block("cbc b2", C, 1'b1);
      chk("cbc idle", busy, 1'b0);

      // Short final block
      start_msg(1'b0, 128'd0);
      send_word(32'h00112233, 1'b1);
      chk("short din", core_din, 128'h00112233000000000000000000000000);
      recv_block("short", 128'hffeeddccffffffffffffffffffffffff, 1'b1);
      chk("short idle", busy, 1'b0);

      // Backpressure at idx 1 with in_valid held
      start_msg(1'b0, 128'd0);
      send_block(P, 1'b1);
      recv_word("bp w0", 32'h69c4e0d8, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'hdeadbeef;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("bp stall%0d data", i), out_data, 32'h6a7b0430);
         chk($sformatf("bp stall%0d in_ready", i), in_ready, 1'b0);
         chk($sformatf("bp stall%0d valid", i), out_valid, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      recv_word("bp w1", 32'h6a7b0430, 1'b0);
      recv_word("bp w2", 32'hd8cdb780, 1'b0);
      recv_word("bp w3", 32'h70b4c55a, 1'b1);
      chk("bp idle", busy, 1'b0);

      // Timeout: error exactly WAIT_MAX cycles after WAIT entry
      never_done = 1'b1;
      start_msg(1'b0, 128'd0);
      send_block(P, 1'b1);
      chk("to entry error", error, 1'b0);
      repeat (WAIT_MAX - 1) tick();
      chk("to early error", error, 1'b0);
      chk("to early busy", busy, 1'b1);
      tick();
      chk("to error", error, 1'b1);
      chk("to idle", busy, 1'b0);
      chk("to core_reset", core_reset, 1'b1);
      never_done = 1'b0;
      start_msg(1'b0, 128'd0);
      chk("to error cleared", error, 1'b0);

      // Stale done held high across WAIT entry
      force_done = 1'b1;
      send_block(P, 1'b1);
      chk("stale c0 valid", out_valid, 1'b0);
      chk("stale c0 core_reset", core_reset, 1'b0);
      tick();
      chk("stale c1 valid", out_valid, 1'b0);
      tick();
      chk("stale c2 valid", out_valid, 1'b0);
      tick();
      chk("stale accept valid", out_valid, 1'b1);
      force_done = 1'b0;
      recv_block("stale", C, 1'b1);

      // Reset asserted in WAIT
      start_msg(1'b0, 128'd0);
      send_block(P, 1'b1);
      chk("rw in wait", core_reset, 1'b0);
      reset = 1'b1;
      #1;
      chk("rw busy", busy, 1'b0);
      chk("rw core_reset", core_reset, 1'b1);
      chk("rw out_valid", out_valid, 1'b0);
      tick();
      reset = 1'b0;
      tick();

      // Recovery after reset
      start_msg(1'b0, 128'd0);
      send_block(P, 1'b1);
      recv_block("recover", C, 1'b1);
      chk("recover idle", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
